// File: rtl/b_mux_sequencer_if.sv
// b_mux_sequencer_if: job handshake and per-lane mux select/valid bundle.
interface b_mux_sequencer_if #(
    parameter int CASCADE_LEN = 32,
    parameter int BLK_W = 16
);
    logic start;
    logic [BLK_W-1:0] num_row_blocks;
    logic busy;
    logic done;
    logic [CASCADE_LEN-1:0][4:0] muxsel;
    logic [CASCADE_LEN-1:0] lane_valid;
    logic [4:0] col_idx;
    modport master (output start, num_row_blocks, input busy, done, muxsel, lane_valid, col_idx);
    modport slave (input start, num_row_blocks, output busy, done, muxsel, lane_valid, col_idx);
endinterface

// File: rtl/b_mux_sequencer.sv
// b_mux_sequencer: sweeps B columns 0..N-1 per row block and skews the select
// and valid per cascade lane, with valid delayed one extra stage for the mux flop.
module b_mux_sequencer #(
    parameter int CASCADE_LEN = 32,
    parameter int N = 32,
    parameter int BLK_W = 16
) (
    input logic clk,
    input logic reset,
    b_mux_sequencer_if.slave bus
);
    localparam int DW = $clog2(CASCADE_LEN + 1);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;
    state_t state, state_n;
    logic [4:0] col, col_n;
    logic [BLK_W-1:0] blk, blk_n, r, r_n;
    logic [DW-1:0] drn, drn_n;
    logic issue_v, wrap;
    logic [CASCADE_LEN-1:0][4:0] sel;
    logic [CASCADE_LEN-1:0] v, lv;
    assign wrap = col == 5'(N - 1);
    always_comb begin
        state_n = state;
        col_n = col;
        blk_n = blk;
        r_n = r;
        drn_n = drn;
        issue_v = 1'b0;
        case (state)
            IDLE: if (bus.start) begin
                r_n = bus.num_row_blocks;
                col_n = '0;
                blk_n = '0;
                state_n = bus.num_row_blocks == '0 ? FIN : RUN;
            end
            RUN: begin
                issue_v = 1'b1;
                col_n = wrap ? 5'd0 : col + 5'd1;
                blk_n = wrap ? blk + BLK_W'(1) : blk;
                if (wrap && blk == r - BLK_W'(1)) begin
                    state_n = DRAIN;
                    blk_n = '0;
                    drn_n = DW'(CASCADE_LEN);
                end
            end
            DRAIN: begin
                state_n = drn == '0 ? FIN : DRAIN;
                drn_n = drn == '0 ? drn : drn - DW'(1);
            end
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            col <= '0;
            blk <= '0;
            r <= '0;
            drn <= '0;
            sel <= '0;
            v <= '0;
            lv <= '0;
        end else begin
            state <= state_n;
            col <= col_n;
            blk <= blk_n;
            r <= r_n;
            drn <= drn_n;
            // idle slots shift in column 0 so the chain settles to all-zero
            sel[0] <= issue_v ? col : 5'd0;
            v[0] <= issue_v;
            for (int k = 1; k < CASCADE_LEN; k++) begin
                sel[k] <= sel[k-1];
                v[k] <= v[k-1];
            end
            lv <= v;
        end
    end
    assign bus.busy = state == RUN || state == DRAIN;
    assign bus.done = state == FIN;
    assign bus.muxsel = sel;
    assign bus.lane_valid = lv;
    assign bus.col_idx = col;
endmodule

// File: tb/tb_b_mux_sequencer.sv
// tb_b_mux_sequencer: randomized jobs checked against a cycle-index schedule model,
// plus a full-size mux scoreboard run.
module tb_b_mux_sequencer;
    logic clk = 1'b0;
    logic rst_a, rst_b;
    int checks = 0;
    int errors = 0;
    int q[32][$];
    int hits[32];
    logic [31:0][4:0] prev;

    always #5 clk = ~clk;

    b_mux_sequencer_if #(.CASCADE_LEN(4), .BLK_W(16)) ia ();
    b_mux_sequencer_if #(.CASCADE_LEN(32), .BLK_W(16)) ib ();

    b_mux_sequencer #(.CASCADE_LEN(4), .N(8), .BLK_W(16)) dut_a (.clk(clk), .reset(rst_a), .bus(ia));
    b_mux_sequencer #(.CASCADE_LEN(32), .N(32), .BLK_W(16)) dut_b (.clk(clk), .reset(rst_b), .bus(ib));

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Cycle c counts from the first cycle after the start edge; item i is column i%8
    // and shows on lane k's select at c=i+1+k and on its valid at c=i+2+k.
    task automatic check_a(input int c, input int t, input string p);
        logic [19:0] es;
        logic [3:0] ev;
        for (int k = 0; k < 4; k++) begin
            es[k*5 +: 5] = (c - 1 - k >= 0 && c - 1 - k < t) ? 5'((c - 1 - k) % 8) : 5'd0;
            ev[k] = c - 2 - k >= 0 && c - 2 - k < t;
        end
        check($sformatf("%s_sel@%0d", p, c), 64'(ia.muxsel), 64'(es));
        check($sformatf("%s_valid@%0d", p, c), 64'(ia.lane_valid), 64'(ev));
        check($sformatf("%s_busy@%0d", p, c), 64'(ia.busy), 64'(t > 0 && c >= 0 && c <= t + 4));
        check($sformatf("%s_done@%0d", p, c), 64'(ia.done), 64'(t > 0 ? c == t + 5 : c == 0));
        check($sformatf("%s_col@%0d", p, c), 64'(ia.col_idx), 64'((c >= 0 && c < t) ? c % 8 : 0));
    endtask

    task automatic run_job(input int rb, input bit noise);
        int t = rb * 8;
        int fin = rb == 0 ? 0 : t + 5;
        ia.num_row_blocks = 16'(rb);
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        for (int c = 0; ; c++) begin
            check_a(c, t, $sformatf("job_r%0d", rb));
            if (c > fin) break;
            if (noise) begin
                ia.start = $urandom_range(2) == 0;
                ia.num_row_blocks = 16'($urandom);
            end
            @(posedge clk); #1;
        end
        ia.start = 1'b0;
    endtask

    initial begin
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.start = 1'b0;
        ia.num_row_blocks = '0;
        ib.start = 1'b0;
        ib.num_row_blocks = '0;
        repeat (2) @(posedge clk);
        #1;
        check_a(-100, 0, "reset");
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(posedge clk); #1;
        run_job(1, 0);
        run_job(3, 0);
        run_job(0, 0);
        run_job(2, 1);
        for (int j = 0; j < 8; j++) run_job($urandom_range(4), 1);
        // reset during RUN cycle 5 discards the job
        ia.num_row_blocks = 16'd2;
        ia.start = 1'b1;
        @(posedge clk); #1;
        ia.start = 1'b0;
        for (int c = 0; c <= 5; c++) begin
            check_a(c, 16, "pre_rst");
            if (c < 5) begin
                @(posedge clk); #1;
            end
        end
        rst_a = 1'b1;
        @(posedge clk); #1;
        check_a(-100, 0, "mid_rst");
        rst_a = 1'b0;
        for (int c = 0; c < 24; c++) begin
            @(posedge clk); #1;
            check_a(-100, 0, "post_rst");
        end
        run_job(1, 0);
        // full-size run: mux output is the select flopped once, valid must line up with it
        for (int i = 0; i < 64; i++)
            for (int k = 0; k < 32; k++) q[k].push_back(i % 32);
        for (int k = 0; k < 32; k++) hits[k] = 0;
        prev = '0;
        ib.num_row_blocks = 16'd2;
        ib.start = 1'b1;
        @(posedge clk); #1;
        ib.start = 1'b0;
        for (int c = 0; c <= 98; c++) begin
            for (int k = 0; k < 32; k++) begin
                if (ib.lane_valid[k]) begin
                    if (q[k].size() == 0) check($sformatf("b_extra%0d@%0d", k, c), 64'd1, 64'd0);
                    else begin
                        check($sformatf("b_mux%0d@%0d", k, c), 64'(prev[k]), 64'(q[k].pop_front()));
                        hits[k]++;
                    end
                end
            end
            check($sformatf("b_done@%0d", c), 64'(ib.done), 64'(c == 97));
            check($sformatf("b_busy@%0d", c), 64'(ib.busy), 64'(c <= 96));
            prev = ib.muxsel;
            @(posedge clk); #1;
        end
        for (int k = 0; k < 32; k++) check($sformatf("b_hits%0d", k), 64'(hits[k]), 64'd64);
        check("b_sel_zero", 64'(ib.muxsel == '0), 64'd1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
